// File: rtl/life_pkg.sv
// Shared definitions for the Life row scanner and its column blocks:
// scan state encoding and default grid geometry.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_X     = 8;
  localparam int DEF_Y     = 8;
  localparam int DEF_LOG2X = 3;
  localparam int DEF_LOG2Y = 3;

endpackage

// File: rtl/life_row_mem.sv
// Grid row storage: Y rows of X cells, one synchronous write port,
// one combinational read port, asynchronous active-low clear.
module life_row_mem #(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2Y = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [LOG2Y-1:0] waddr_i,
  input  logic [X-1:0]     wdata_i,
  input  logic [LOG2Y-1:0] raddr_i,
  output logic [X-1:0]     rdata_o
);

  logic [X-1:0] mem_q [Y];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Y; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/life_row_scan.sv
// Frame scanner: walks cnt over X*Y positions and presents the grid row
// selected by the row field of cnt. Optional looping via LIFE_SCAN_LOOP_EN.
module life_row_scan
  import life_pkg::*;
#(
  parameter int X     = DEF_X,
  parameter int Y     = DEF_Y,
  parameter int LOG2X = DEF_LOG2X,
  parameter int LOG2Y = DEF_LOG2Y
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   hold,
  input  logic                   stop,
  input  logic                   wr_en,
  input  logic [LOG2Y-1:0]       wr_addr,
  input  logic [X-1:0]           wr_data,
  output logic [LOG2X+LOG2Y-1:0] cnt,
  output logic [X-1:0]           top_row,
  output logic                   valid,
  output logic                   busy,
  output logic                   done,
  output logic                   wr_err
);

  localparam int CW = LOG2X + LOG2Y;
  localparam logic [CW-1:0] LAST = CW'(X * Y - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [X-1:0]   top_row_q, top_row_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           wr_err_q, wr_err_d;
  logic           load_row;
  logic           mem_we;
  logic [LOG2Y-1:0] rd_addr;
  logic [X-1:0]   mem_row, rd_row;
  logic           frame_continue;

`ifdef LIFE_SCAN_LOOP_EN
  logic stop_seen_q, stop_seen_d;

  // stop is remembered per frame; a wrap into the next frame clears it
  always_comb begin
    stop_seen_d = stop_seen_q;
    if (state_q != SCAN) begin
      stop_seen_d = 1'b0;
    end else if (!hold && cnt_q == LAST && frame_continue) begin
      stop_seen_d = 1'b0;
    end else if (stop) begin
      stop_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stop_seen_q <= 1'b0;
    else        stop_seen_q <= stop_seen_d;
  end

  assign frame_continue = ~(stop_seen_q | stop);
`else
  logic unused_stop;
  assign unused_stop    = stop;
  assign frame_continue = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    wr_err_d = wr_en && (state_q == SCAN);
    load_row = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d  = SCAN;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          load_row = 1'b1;
        end
      end
      SCAN: begin
        busy_d = 1'b1;
        if (!hold) begin
          load_row = 1'b1;
          valid_d  = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d  = '0;
            done_d = 1'b1;
            if (!frame_continue) begin
              state_d = DONE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Writes are only accepted outside SCAN; a write coinciding with an
  // accepted start is forwarded so the first row already sees it.
  assign mem_we  = wr_en && (state_q != SCAN);
  assign rd_addr = cnt_d[CW-1:LOG2X];

  always_comb begin
    rd_row    = (mem_we && wr_addr == rd_addr) ? wr_data : mem_row;
    top_row_d = load_row ? rd_row : top_row_q;
  end

  life_row_mem #(
    .X     (X),
    .Y     (Y),
    .LOG2Y (LOG2Y)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (mem_we),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (mem_row)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      top_row_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      top_row_q <= top_row_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign cnt     = cnt_q;
  assign top_row = top_row_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_life_row_scan.sv
// Self-checking bench for life_row_scan: directed scenarios plus randomized
// frames, checked against a frame-level reference grid model.
module tb_life_row_scan;

  logic       clk = 1'b0;
  logic       reset, start, hold, stop, wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] cnt;
  logic [7:0] top_row;
  logic       valid, busy, done, wr_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] ref_grid [8];

  life_row_scan #(
    .X     (8),
    .Y     (8),
    .LOG2X (3),
    .LOG2Y (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .hold    (hold),
    .stop    (stop),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cnt     (cnt),
    .top_row (top_row),
    .valid   (valid),
    .busy    (busy),
    .done    (done),
    .wr_err  (wr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_row(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    ref_grid[a] = d;
    chk("idle_wr_err", wr_err, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cnt"},     cnt, 0);
    chk({tag, "_top_row"}, top_row, 0);
    chk({tag, "_valid"},   valid, 0);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_done"},    done, 0);
    chk({tag, "_wr_err"},  wr_err, 0);
  endtask

  // One complete scan (several frames when looping) from IDLE back to IDLE.
  task automatic run_frame(input int hold_at, input int hold_len,
                           input int wr_at, input logic [2:0] wa, input logic [7:0] wd,
                           input bit swr, input logic [2:0] sa, input logic [7:0] sd,
                           input int stop_frame);
    int nfr;
    bit wr_prev;
`ifdef LIFE_SCAN_LOOP_EN
    nfr = stop_frame + 1;
`else
    nfr = 1;
`endif
    start = 1'b1;
    if (swr) begin
      wr_en = 1'b1; wr_addr = sa; wr_data = sd;
      ref_grid[sa] = sd;
    end
    tick();
    start = 1'b0; wr_en = 1'b0;
    wr_prev = 1'b0;
    for (int f = 0; f < nfr; f++) begin
      for (int k = 0; k < 64; k++) begin
        chk("valid",  valid, 1);
        chk("busy",   busy, 1);
        chk("cnt",    cnt, k);
        chk("done",   done, (f > 0 && k == 0));
        chk("wr_err", wr_err, wr_prev);
        if (k % 8 == 0) chk("top_row", top_row, ref_grid[k / 8]);
        if (k == hold_at && f == 0) begin
          hold = 1'b1;
          repeat (hold_len) begin
            tick();
            chk("hold_cnt",   cnt, k);
            chk("hold_valid", valid, 0);
            chk("hold_done",  done, 0);
          end
          hold = 1'b0;
        end
        wr_prev = (k == wr_at && f == 0);
        wr_en   = wr_prev; wr_addr = wa; wr_data = wd;
        start   = (k == 40);
        stop    = (k == 5 && f == stop_frame);
        tick();
        wr_en = 1'b0; start = 1'b0; stop = 1'b0;
      end
    end
    chk("end_done",   done, 1);
    chk("end_valid",  valid, 0);
    chk("end_busy",   busy, 0);
    chk("end_cnt",    cnt, 0);
    chk("end_wr_err", wr_err, wr_prev);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_done",  done, 0);
    chk("idle_busy",  busy, 0);
    chk("idle_valid", valid, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; hold = 1'b0; stop = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 8; i++) ref_grid[i] = '0;
    repeat (2) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Walking-one grid, plain frame
    for (int i = 0; i < 8; i++) wr_row(3'(i), 8'(1 << i));
    run_frame(-1, 0, -1, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 0);

    // Hold for three cycles at cnt=20
    run_frame(20, 3, -1, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 0);

    // Write during scan is dropped; rerun shows row 2 unchanged
    run_frame(-1, 0, 10, 3'd2, 8'hFF, 1'b0, 3'd0, 8'h00, 0);
    run_frame(-1, 0, -1, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 0);

    // Write together with start is visible at cnt=0
    run_frame(-1, 0, -1, 3'd0, 8'h00, 1'b1, 3'd0, 8'hAA, 0);

    // Reset in the middle of a frame
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    chk("pre_reset_cnt", cnt, 30);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) begin
      tick();
      chk("reset_no_done", done, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) ref_grid[i] = '0;
    tick();
    check_all_zero("after_release");
    run_frame(-1, 0, -1, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 0);

`ifdef LIFE_SCAN_LOOP_EN
    // stop during the second frame: loop once, then end via DONE
    for (int i = 0; i < 8; i++) wr_row(3'(i), 8'($urandom));
    run_frame(-1, 0, -1, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1);
`endif

    // Randomized frames
    for (int r = 0; r < 8; r++) begin
      int nw;
      nw = int'($urandom_range(1, 4));
      for (int w = 0; w < nw; w++) wr_row(3'($urandom_range(0, 7)), 8'($urandom));
      run_frame(int'($urandom_range(0, 62)), int'($urandom_range(1, 3)),
                int'($urandom_range(0, 60)), 3'($urandom_range(0, 7)), 8'($urandom),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
